// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-level ALU slice: the 4-bit ALU opcode
// encoding, the 2-bit main-decoder ALU control class, the default datapath
// width and the funct3 values the ALU decoder cares about.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_INVALID = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    CTRL_MEM    = 2'b00,
    CTRL_BRANCH = 2'b01,
    CTRL_RTYPE  = 2'b10,
    CTRL_ITYPE  = 2'b11
  } alu_ctrl_t;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
// Purely combinational ALU decoder: maps the main decoder's ALU class plus the
// instruction funct3 / funct7 bit 30 onto the 4-bit ALU opcode. Anything the
// ALU cannot execute decodes to ALU_INVALID.
// Ports:
//   alu_ctrl  in  2  00 mem(add), 01 branch(sub), 10 R-type, 11 I-type
//   funct3    in  3  instruction funct3
//   funct7_5  in  1  instruction bit 30 (only meaningful for R-type add/sub)
//   alu_op    out 4  decoded ALU opcode
// -----------------------------------------------------------------------------
module alu_control
  import alu_pkg::*;
(
  input  logic [1:0] alu_ctrl,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  alu_op_t op;

  // Loads/stores always add and branches always subtract. R- and I-type share
  // the funct3 table; only R-type honours bit 30 to pick SUB, because for
  // I-type that bit belongs to the immediate (addi has no subtract form).
  always_comb begin
    op = ALU_INVALID;
    unique case (alu_ctrl_t'(alu_ctrl))
      CTRL_MEM:    op = ALU_ADD;
      CTRL_BRANCH: op = ALU_SUB;
      CTRL_RTYPE, CTRL_ITYPE: begin
        case (funct3)
          F3_ADD_SUB: op = (alu_ctrl_t'(alu_ctrl) == CTRL_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          F3_AND:     op = ALU_AND;
          F3_OR:      op = ALU_OR;
          default:    op = ALU_INVALID;
        endcase
      end
      default:     op = ALU_INVALID;
    endcase
  end

  assign alu_op = op;

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// ID/EX boundary register in front of the ALU. Accepts a decoded instruction
// over valid/ready, decodes the ALU opcode, resolves operand forwarding from
// EX/MEM and MEM/WB, applies the immediate select and registers the results so
// the ALU is driven straight from flops. Supports backpressure and flush.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid / in_ready              upstream handshake (in_ready is comb.)
//   alu_ctrl, funct3, funct7_5       decode fields
//   alu_src, imm                     1: operand B is imm, 0: forwarded rs2
//   rs1_addr/rs2_addr/rs1_data/rs2_data  source indices and regfile data
//   exmem_wr_en/exmem_rd/exmem_result    EX/MEM forwarding source
//   memwb_wr_en/memwb_rd/memwb_result    MEM/WB forwarding source
//   flush                            kill held and incoming instruction
//   out_valid / out_ready            downstream handshake
//   alu_op, in_a, in_b, illegal      registered ALU inputs and decode status
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = alu_pkg::XLEN,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_ctrl,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              alu_src,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic              exmem_wr_en,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_wr_en,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   in_a,
  output logic [XLEN-1:0]   in_b,
  output logic              illegal
);

  logic [3:0]      dec_op;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] opnd_b;
  logic            capture;

  alu_control u_alu_control (
    .alu_ctrl (alu_ctrl),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (dec_op)
  );

  // Operand bypass for one source. The younger EX/MEM result wins over
  // MEM/WB, and x0 is never bypassed since it is hard-wired to zero even if a
  // preceding instruction nominally "wrote" it.
  function automatic logic [XLEN-1:0] forward_operand(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rf_data
  );
    logic [XLEN-1:0] res;
    res = rf_data;
    if (rs != '0) begin
      if (exmem_wr_en && exmem_rd == rs) begin
        res = exmem_result;
      end else if (memwb_wr_en && memwb_rd == rs) begin
        res = memwb_result;
      end
    end
    return res;
  endfunction

  // Operand selection is resolved only at capture time; a held instruction
  // keeps the operands it was captured with, so upstream must stall on hazards.
  always_comb begin
    fwd_a  = forward_operand(rs1_addr, rs1_data);
    fwd_b  = forward_operand(rs2_addr, rs2_data);
    opnd_b = alu_src ? imm : fwd_b;
  end

  // The slot is free when empty or when its occupant leaves this cycle. This
  // deliberately ignores in_valid and flush so upstream sees a stable ready.
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Output register bank. Data registers load only on capture, so they stay
  // frozen while a stalled instruction waits and may hold stale values once
  // out_valid drops. Flush clears valid and suppresses any concurrent capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_op    <= ALU_INVALID;
      in_a      <= '0;
      in_b      <= '0;
      illegal   <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (capture) begin
        alu_op  <= dec_op;
        in_a    <= fwd_a;
        in_b    <= opnd_b;
        illegal <= (dec_op == ALU_INVALID);
      end
    end
  end

endmodule
